monster_hp_arbiter: RTL and testbench
=====================================

Name: monster_hp_arbiter

Overview:
- Shares the single monster-HP update path between the four monster units, replacing fixed-priority selection.
- Latches every add/remove HP event per monster, so no event is lost when several monsters fire in the same cycle.
- Grants pending events round-robin, one add and one remove per cycle at most.
- Sequences the pacman respawn window that follows each remove, and drives the HP counter and pacman logic.

Parameters:
- HP_W, 5, width of HP event values.
- RESPAWN_CYCLES, 64, cycles pacmanRespawn stays high after a granted remove (legal range 2..1023).

Ports:
- clk  in  1  system clock
- resetN  in  1  synchronous active-low reset
- gameActive  in  1  high while gameplay runs; low flushes and blocks all events
- addHPOne/Two/Three/Four  in  HP_W  per-monster add event; nonzero = event this cycle
- removeHPOne/Two/Three/Four  in  HP_W  per-monster remove event; nonzero = event this cycle
- addHPmonsters  out  HP_W  granted add amount, one-cycle pulse, 0 otherwise
- removeHPmonsters  out  HP_W  granted remove amount, one-cycle pulse, 0 otherwise
- pacmanRespawn  out  1  high for the whole respawn window

Behaviour:
- Clock and reset:
  - Reset is sampled only on posedge clk while resetN=0.
  - Reset values: all outputs 0, pending regs 0, both RR pointers 0, state IDLE, respawn counter 0.
  - Reset mid-window aborts the window immediately.
- Pending add, per monster i:
  - Input nonzero: pendAdd[i] <= min(pendAdd[i] + in, 2^HP_W-1); saturating, HP_W+1-bit internal sum.
  - If i is granted in the same cycle, pendAdd[i] <= in (the new arrival is kept, the old value is drained).
- Add arbitration, every cycle:
  - Winner = first i with pendAdd[i]≠0, scanning from addPtr upward mod 4.
  - addHPmonsters <= pendAdd[winner], then pendAdd[winner] clears and addPtr <= winner+1 mod 4.
  - No pending add: addHPmonsters <= 0 and the pointer is unchanged.
  - Latency: input at edge k is latched; output is valid after edge k+1. Throughput is one add per cycle.
- Pending remove: same saturating rule, using pendRem[i] and remPtr.
- Remove FSM, states IDLE and RESPAWN:
  - IDLE with any pendRem≠0:
    - Grant RR winner; removeHPmonsters <= pendRem[winner] for one cycle.
    - Clear all four pendRem (one death per collision cluster).
    - remPtr <= winner+1; pacmanRespawn <= 1; cnt <= RESPAWN_CYCLES-1; go to RESPAWN.
  - RESPAWN:
    - pacmanRespawn stays 1 and cnt decrements.
    - Remove inputs are discarded and never latched (pacman invulnerable).
    - At cnt==0: pacmanRespawn <= 0 and go to IDLE. Total high time is exactly RESPAWN_CYCLES cycles.
  - A remove arriving in the first IDLE cycle after the window is accepted normally.
  - Add arbitration continues unaffected during RESPAWN.
- gameActive=0:
  - Same cycle: all pending regs clear, inputs are ignored, and addHPmonsters/removeHPmonsters <= 0.
  - Any respawn window in progress completes normally.
  - Pointers are held.
- Simultaneous add and remove from the same monster are independent; both are latched.

Decomposition:
- Package monster_hp_pkg:
  - HP_W default, N_MONSTERS=4.
  - typedef logic [HP_W-1:0] hp_t.
  - enum {IDLE, RESPAWN} resp_state_t.
  - Saturating-add function sat_add_hp.
- Sub-module rr_pick4: combinational 4-way round-robin picker (req[3:0], ptr[1:0] -> valid, idx[1:0]), instantiated twice (add, remove).

Test Plan:
- Reset, then addHPOne=3 for one cycle -> addHPmonsters=3 exactly one cycle after the latching edge; all other outputs 0.
- All four adds = 1,2,3,4 in the same cycle, addPtr=0 -> outputs 1,2,3,4 on four consecutive cycles; addPtr ends at 0.
- addHPTwo=20 on two consecutive cycles, with pendAdd[1] not granted in between (higher-priority add pending) -> saturates at 31.
- removeHPThree=5 with RESPAWN_CYCLES=4 -> removeHPmonsters=5 for one cycle and pacmanRespawn high exactly 4 cycles; removeHPOne=2 in window cycle 2 -> never output.
- removeHPOne and removeHPFour simultaneous, remPtr=0 -> only 1's value output; pendRem cleared; next remove from Four after the window is granted and remPtr advances to 0.
- gameActive=0 with pending adds and an active window -> no further add/remove pulses, pacmanRespawn finishes its count; resetN=0 mid-window -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/monster_hp_pkg.sv
// Shared types and helpers for the monster HP event arbiter.
package monster_hp_pkg;
  localparam int HP_W       = 5;
  localparam int N_MONSTERS = 4;
  localparam int CNT_W      = 10;

  typedef logic [HP_W-1:0] hp_t;
  typedef enum logic {IDLE, RESPAWN} resp_state_t;

  // Saturating HP add; the extra sum bit catches overflow.
  function automatic hp_t sat_add_hp(hp_t a, hp_t b);
    logic [HP_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[HP_W] ? {HP_W{1'b1}} : s[HP_W-1:0];
  endfunction
endpackage

// File: rtl/monster_hp_arbiter_rr_pick4.sv
// Combinational 4-way round-robin picker: first set req at or after ptr.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic       valid,
  output logic [1:0] idx
);
  logic [1:0] cand;

  // Scan farthest-first so the nearest requester overwrites the result.
  always_comb begin
    valid = 1'b0;
    idx   = ptr;
    cand  = '0;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr + 2'(k);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end
endmodule

// File: rtl/monster_hp_arbiter.sv
// Latches per-monster add/remove HP events, grants them round-robin and
// sequences the pacman respawn window that follows each granted remove.
module monster_hp_arbiter #(
  parameter int HP_W           = monster_hp_pkg::HP_W,
  parameter int RESPAWN_CYCLES = 64
) (
  input  logic            clk,
  input  logic            resetN,
  input  logic            gameActive,
  input  logic [HP_W-1:0] addHPOne,
  input  logic [HP_W-1:0] addHPTwo,
  input  logic [HP_W-1:0] addHPThree,
  input  logic [HP_W-1:0] addHPFour,
  input  logic [HP_W-1:0] removeHPOne,
  input  logic [HP_W-1:0] removeHPTwo,
  input  logic [HP_W-1:0] removeHPThree,
  input  logic [HP_W-1:0] removeHPFour,
  output logic [HP_W-1:0] addHPmonsters,
  output logic [HP_W-1:0] removeHPmonsters,
  output logic            pacmanRespawn
);
  import monster_hp_pkg::*;

  logic [N_MONSTERS-1:0][HP_W-1:0] addIn, remIn, pendAdd, pendRem;
  logic [N_MONSTERS-1:0]           addReq, remReq;
  logic [1:0]                      addPtr, remPtr, addIdx, remIdx;
  logic                            addVld, remVld, remGrant;
  resp_state_t                     state, nextState;
  logic [CNT_W-1:0]                cnt;

  assign addIn = {addHPFour, addHPThree, addHPTwo, addHPOne};
  assign remIn = {removeHPFour, removeHPThree, removeHPTwo, removeHPOne};

  for (genvar i = 0; i < N_MONSTERS; i++) begin : g_req
    assign addReq[i] = |pendAdd[i];
    assign remReq[i] = |pendRem[i];
  end

  rr_pick4 u_addPick (.req(addReq), .ptr(addPtr), .valid(addVld), .idx(addIdx));
  rr_pick4 u_remPick (.req(remReq), .ptr(remPtr), .valid(remVld), .idx(remIdx));

  // Respawn window runs to completion even while gameplay is paused.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nextState;
      if (remGrant)
        cnt <= CNT_W'(RESPAWN_CYCLES - 1);
      else if (state == RESPAWN && cnt != '0)
        cnt <= cnt - 1'b1;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (remGrant) nextState = RESPAWN;
      RESPAWN: if (cnt == '0) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    remGrant      = (state == IDLE) && remVld && gameActive;
    pacmanRespawn = (state == RESPAWN);
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      pendAdd          <= '0;
      pendRem          <= '0;
      addPtr           <= '0;
      remPtr           <= '0;
      addHPmonsters    <= '0;
      removeHPmonsters <= '0;
    end else if (!gameActive) begin
      pendAdd          <= '0;
      pendRem          <= '0;
      addHPmonsters    <= '0;
      removeHPmonsters <= '0;
    end else begin
      addHPmonsters    <= addVld ? pendAdd[addIdx] : '0;
      removeHPmonsters <= remGrant ? pendRem[remIdx] : '0;
      if (addVld)   addPtr <= addIdx + 2'd1;
      if (remGrant) remPtr <= remIdx + 2'd1;
      for (int i = 0; i < N_MONSTERS; i++) begin
        // A granted slot drains its old value but keeps a same-cycle arrival.
        pendAdd[i] <= sat_add_hp((addVld && addIdx == 2'(i)) ? hp_t'(0) : pendAdd[i], addIn[i]);
        // One death per collision cluster; pacman is invulnerable in the window.
        if (remGrant || state == RESPAWN)
          pendRem[i] <= '0;
        else
          pendRem[i] <= sat_add_hp(pendRem[i], remIn[i]);
      end
    end
  end
endmodule

// File: tb/tb_monster_hp_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// cycle-level behavioural model of the arbiter rules.
module tb_monster_hp_arbiter;
  localparam int RC = 4;

  logic       clk = 1'b0;
  logic       resetN, gameActive;
  logic [4:0] ai [4];
  logic [4:0] ri [4];
  logic [4:0] addOut, remOut;
  logic       resp;

  int n_tests = 0;
  int n_fail  = 0;

  // behavioural model state
  int pa [4];
  int pr [4];
  int aptr = 0, rptr = 0, winLeft = 0, expAdd = 0, expRem = 0;

  monster_hp_arbiter #(.HP_W(5), .RESPAWN_CYCLES(RC)) dut (
    .clk(clk), .resetN(resetN), .gameActive(gameActive),
    .addHPOne(ai[0]), .addHPTwo(ai[1]), .addHPThree(ai[2]), .addHPFour(ai[3]),
    .removeHPOne(ri[0]), .removeHPTwo(ri[1]), .removeHPThree(ri[2]), .removeHPFour(ri[3]),
    .addHPmonsters(addOut), .removeHPmonsters(remOut), .pacmanRespawn(resp)
  );

  always #5 clk = ~clk;

  function automatic int sat31(int v);
    return (v > 31) ? 31 : v;
  endfunction

  // One clock edge of the arbiter rules, applied to the inputs held at that edge.
  task automatic model_step();
    int w;
    if (!resetN) begin
      for (int i = 0; i < 4; i++) begin pa[i] = 0; pr[i] = 0; end
      aptr = 0; rptr = 0; winLeft = 0; expAdd = 0; expRem = 0;
    end else if (!gameActive) begin
      for (int i = 0; i < 4; i++) begin pa[i] = 0; pr[i] = 0; end
      expAdd = 0; expRem = 0;
      if (winLeft > 0) winLeft--;
    end else begin
      w = -1;
      for (int k = 0; k < 4; k++)
        if (w < 0 && pa[(aptr + k) % 4] != 0) w = (aptr + k) % 4;
      expAdd = 0;
      if (w >= 0) begin expAdd = pa[w]; pa[w] = 0; aptr = (w + 1) % 4; end
      for (int i = 0; i < 4; i++) pa[i] = sat31(pa[i] + int'(ai[i]));
      expRem = 0;
      if (winLeft > 0) winLeft--;
      else begin
        w = -1;
        for (int k = 0; k < 4; k++)
          if (w < 0 && pr[(rptr + k) % 4] != 0) w = (rptr + k) % 4;
        if (w >= 0) begin
          expRem = pr[w];
          for (int i = 0; i < 4; i++) pr[i] = 0;
          rptr = (w + 1) % 4;
          winLeft = RC;
        end else begin
          for (int i = 0; i < 4; i++) pr[i] = sat31(pr[i] + int'(ri[i]));
        end
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    for (int i = 0; i < 4; i++) begin ai[i] = '0; ri[i] = '0; end
  endtask

  task automatic test_reset();
    resetN = 1'b0; gameActive = 1'b1; clear_in();
    tick(); tick();
    n_tests++; if (addOut !== 5'd0) begin n_fail++; $display("FAIL reset_add: got %0d expected 0", addOut); end
    n_tests++; if (remOut !== 5'd0) begin n_fail++; $display("FAIL reset_rem: got %0d expected 0", remOut); end
    n_tests++; if (resp !== 1'b0) begin n_fail++; $display("FAIL reset_resp: got %0b expected 0", resp); end
    resetN = 1'b1;
  endtask

  task automatic test_rr_all();
    ai[0] = 5'd1; ai[1] = 5'd2; ai[2] = 5'd3; ai[3] = 5'd4;
    tick(); clear_in();
    for (int k = 0; k < 4; k++) begin
      tick();
      n_tests++;
      if (addOut !== 5'(k + 1)) begin n_fail++; $display("FAIL rr_all_%0d: got %0d expected %0d", k, addOut, k + 1); end
    end
    n_tests++; if (dut.addPtr !== 2'd0) begin n_fail++; $display("FAIL rr_all_ptr: got %0d expected 0", dut.addPtr); end
  endtask

  task automatic test_single_add();
    ai[0] = 5'd3;
    tick(); clear_in();
    n_tests++; if (addOut !== 5'd0) begin n_fail++; $display("FAIL single_early: got %0d expected 0", addOut); end
    tick();
    n_tests++; if (addOut !== 5'd3) begin n_fail++; $display("FAIL single_add: got %0d expected 3", addOut); end
    n_tests++; if (remOut !== 5'd0 || resp !== 1'b0) begin n_fail++; $display("FAIL single_others: got rem=%0d resp=%0b expected 0 0", remOut, resp); end
    tick();
    n_tests++; if (addOut !== 5'd0) begin n_fail++; $display("FAIL single_pulse: got %0d expected 0", addOut); end
  endtask

  task automatic test_saturate();
    ai[2] = 5'd1; tick(); clear_in(); tick();   // moves addPtr to 3
    n_tests++; if (addOut !== 5'd1) begin n_fail++; $display("FAIL sat_setup: got %0d expected 1", addOut); end
    ai[0] = 5'd5; ai[1] = 5'd20; ai[3] = 5'd5;
    tick();
    ai[0] = 5'd0; ai[3] = 5'd0;
    tick(); clear_in();
    n_tests++; if (addOut !== 5'd5) begin n_fail++; $display("FAIL sat_first: got %0d expected 5", addOut); end
    tick();
    n_tests++; if (addOut !== 5'd5) begin n_fail++; $display("FAIL sat_second: got %0d expected 5", addOut); end
    tick();
    n_tests++; if (addOut !== 5'd31) begin n_fail++; $display("FAIL sat_value: got %0d expected 31", addOut); end
  endtask

  task automatic test_respawn();
    int hi, bad;
    ri[2] = 5'd5; tick(); clear_in();
    n_tests++; if (remOut !== 5'd0) begin n_fail++; $display("FAIL resp_early: got %0d expected 0", remOut); end
    tick();
    n_tests++; if (remOut !== 5'd5 || resp !== 1'b1) begin n_fail++; $display("FAIL resp_grant: got rem=%0d resp=%0b expected 5 1", remOut, resp); end
    hi = 1; bad = 0;
    for (int i = 0; i < 8; i++) begin
      ri[0] = (i == 1) ? 5'd2 : 5'd0;
      tick();
      if (resp) hi++;
      if (remOut !== 5'd0) bad++;
    end
    clear_in();
    n_tests++; if (hi != RC) begin n_fail++; $display("FAIL resp_len: got %0d expected %0d", hi, RC); end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL resp_discard: got %0d pulses expected 0", bad); end
  endtask

  task automatic test_simul_remove();
    int bad;
    resetN = 1'b0; tick(); resetN = 1'b1;
    ri[0] = 5'd7; ri[3] = 5'd9; tick(); clear_in(); tick();
    n_tests++; if (remOut !== 5'd7) begin n_fail++; $display("FAIL simul_grant: got %0d expected 7", remOut); end
    n_tests++; if (dut.remPtr !== 2'd1) begin n_fail++; $display("FAIL simul_ptr: got %0d expected 1", dut.remPtr); end
    n_tests++; if (dut.pendRem !== '0) begin n_fail++; $display("FAIL simul_clear: got %0h expected 0", dut.pendRem); end
    bad = 0;
    for (int i = 0; i < 8; i++) begin tick(); if (remOut !== 5'd0) bad++; end
    n_tests++; if (bad != 0 || resp !== 1'b0) begin n_fail++; $display("FAIL simul_drop: got %0d pulses resp=%0b expected 0 0", bad, resp); end
    ri[3] = 5'd9; tick(); clear_in(); tick();
    n_tests++; if (remOut !== 5'd9) begin n_fail++; $display("FAIL simul_four: got %0d expected 9", remOut); end
    n_tests++; if (dut.remPtr !== 2'd0) begin n_fail++; $display("FAIL simul_ptr2: got %0d expected 0", dut.remPtr); end
    for (int i = 0; i < 6; i++) tick();
  endtask

  task automatic test_game_inactive();
    int hi, bad;
    ai[0] = 5'd4; ai[1] = 5'd6; ri[1] = 5'd3; tick(); clear_in(); tick();
    n_tests++; if (addOut !== 5'd4 || remOut !== 5'd3 || resp !== 1'b1) begin
      n_fail++; $display("FAIL inact_setup: got add=%0d rem=%0d resp=%0b expected 4 3 1", addOut, remOut, resp); end
    gameActive = 1'b0; ai[2] = 5'd7; ri[0] = 5'd1;
    hi = 1; bad = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (resp) hi++;
      if (addOut !== 5'd0 || remOut !== 5'd0) bad++;
    end
    n_tests++; if (hi != RC) begin n_fail++; $display("FAIL inact_len: got %0d expected %0d", hi, RC); end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL inact_pulses: got %0d expected 0", bad); end
    clear_in(); gameActive = 1'b1; tick(); tick();
    n_tests++; if (addOut !== 5'd0) begin n_fail++; $display("FAIL inact_flush: got %0d expected 0", addOut); end
    ri[2] = 5'd1; tick(); clear_in(); tick(); tick();
    n_tests++; if (resp !== 1'b1) begin n_fail++; $display("FAIL midrst_setup: got %0b expected 1", resp); end
    resetN = 1'b0; ai[1] = 5'd2; tick(); clear_in();
    n_tests++; if (resp !== 1'b0 || addOut !== 5'd0 || remOut !== 5'd0) begin
      n_fail++; $display("FAIL midrst: got resp=%0b add=%0d rem=%0d expected 0 0 0", resp, addOut, remOut); end
    resetN = 1'b1;
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      resetN     = ($urandom_range(0, 299) != 0);
      gameActive = ($urandom_range(0, 39) != 0);
      for (int i = 0; i < 4; i++) begin
        ai[i] = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
        ri[i] = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      end
      tick();
      n_tests++; if (addOut !== 5'(expAdd)) begin n_fail++; $display("FAIL rnd_add@%0d: got %0d expected %0d", c, addOut, expAdd); end
      n_tests++; if (remOut !== 5'(expRem)) begin n_fail++; $display("FAIL rnd_rem@%0d: got %0d expected %0d", c, remOut, expRem); end
      n_tests++; if (resp !== (winLeft > 0)) begin n_fail++; $display("FAIL rnd_resp@%0d: got %0b expected %0b", c, resp, winLeft > 0); end
    end
    clear_in();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin pa[i] = 0; pr[i] = 0; end
    test_reset();
    test_rr_all();
    test_single_add();
    test_saturate();
    test_respawn();
    test_simul_remove();
    test_game_inactive();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
